rr_grant_indexer: RTL and testbench
===================================

// Module: rr_grant_indexer
// PURPOSE
//  Round-robin arbiter for 8 requesters that produces a registered 3-bit grant index
//    plus a valid flag. It sits directly upstream of the 3-to-8 one-hot decoder.
//  gnt_idx drives the decoder's 3-bit select input; the decoder's 8-bit one-hot output
//    becomes the per-requester grant/select line.
//  Grants are held until release, and tenure is optionally bounded by a hold timeout.
// PARAMETERS
//  IDX_W     3   index width; the requester count is 2**IDX_W (8 at default)
//  MAX_HOLD  16  max cycles gnt_valid may stay high for one holder; 0 = no limit
// PORTS
//  clk           input   1      single clock; all state changes on posedge
//  rst           input   1      synchronous, active-high reset
//  req           input   8      request vector, bit i = requester i; level-sensitive
//  done          input   1      current holder releases grant; ignored when gnt_valid=0
//  gnt_idx       output  3      index of current holder; feeds the decoder's in[2:0]
//  gnt_valid     output  1      gnt_idx is a live grant; decoder output is don't-care when 0
//  hold_timeout  output  1      one-cycle pulse: the grant was force-released by MAX_HOLD
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, gnt_idx=0, gnt_valid=0, hold_timeout=0,
//    ptr=0, hold_cnt=0. Reset wins over all other inputs, including mid-grant.
//  State is a registered priority pointer ptr[2:0] plus a 2-state FSM:
//  Arbitration (combinational):
//    - winner = (ptr+i) mod 8 for the smallest i in 0..7 with req[(ptr+i) mod 8]=1.
//    - Index arithmetic is IDX_W bits wide and wraps naturally (7+1 -> 0).
//  IDLE:
//    - If |req at posedge: gnt_idx<=winner, gnt_valid<=1, hold_cnt<=0, go to GRANT.
//    - Latency: req sampled at edge k gives gnt_valid=1 in the cycle after edge k.
//    - If no request: stay in IDLE with gnt_valid=0.
//  GRANT:
//    - release = done | ~req[gnt_idx] | timeout.
//    - timeout = (MAX_HOLD!=0) & (hold_cnt==MAX_HOLD-1).
//  On release at posedge:
//    - ptr <= gnt_idx+1 (mod 8). Re-arbitration uses this new ptr in the same cycle.
//    - If any req is set: new gnt_idx<=winner, gnt_valid stays 1 (back-to-back, no
//      bubble), hold_cnt<=0. The just-released index can win again only if it is the
//      sole requester.
//    - Otherwise: gnt_valid<=0, go to IDLE. gnt_idx keeps its last value.
//  No release: gnt_idx is held, and hold_cnt <= hold_cnt+1.
//    - hold_cnt saturates; its width is clog2(MAX_HOLD)+1.
//  hold_timeout<=1 for exactly one cycle after an edge where the release was caused
//    only by timeout (done=0 and req[gnt_idx]=1); otherwise 0.
//  With MAX_HOLD=N, one holder keeps gnt_valid high for at most N consecutive cycles.
//  Simultaneous done and timeout: treated as a normal done; hold_timeout stays 0.
//  req changes on non-holder bits during GRANT have no effect until the next release.
//  gnt_idx changes only at a new grant, so it is glitch-free into the decoder.
// TESTING
//  1. rst, then req=8'b0000_0100
//     -> after 1 edge: gnt_valid=1, gnt_idx=2, decoder out=8'b0000_0100.
//  2. ptr=0, req=8'b1000_0001 -> gnt_idx=0. Pulse done -> next cycle gnt_idx=7 with
//     gnt_valid held 1. Pulse done -> gnt_idx=0.
//  3. Holder 3 drops req[3] with done=0, while req=8'b0010_0000
//     -> next cycle gnt_idx=5, ptr=4.
//  4. MAX_HOLD=16, req=8'b0000_0010 held, done=0
//     -> gnt_valid high exactly 16 cycles, then hold_timeout=1 for 1 cycle.
//     -> Sole requester is re-granted: gnt_idx=1, gnt_valid stays 1.
//  5. Grant of index 6 released, so ptr=7; req=8'b0100_0001
//     -> wrap-around search picks gnt_idx=0, not 6.
//  6. rst asserted mid-GRANT with req=8'hFF
//     -> next cycle gnt_valid=0, gnt_idx=0.
//     -> After rst drops: first grant is gnt_idx=0 (ptr back to 0).

Source files
------------

// File: rtl/rr_grant_indexer.sv
// rr_grant_indexer
//   Round-robin arbiter for 2**IDX_W requesters. It produces a registered
//   grant index and a valid flag that drive the select input of a one-hot
//   decoder. A grant is held until the holder signals done, drops its request,
//   or reaches the optional MAX_HOLD tenure limit.
//
// Ports
//   clk           clock, all state changes on posedge
//   rst           synchronous active-high reset
//   req           level-sensitive request vector, bit i = requester i
//   done          current holder releases its grant (ignored while idle)
//   gnt_idx       index of the current holder (decoder select)
//   gnt_valid     gnt_idx is a live grant
//   hold_timeout  one-cycle pulse after a grant was force-released by MAX_HOLD
//
// state | meaning
// IDLE  | no grant outstanding, arbitrate on any request
// GRANT | gnt_idx holds the grant until release

module rr_grant_indexer #(
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [(1<<IDX_W)-1:0]   req,
  input  logic                    done,
  output logic [IDX_W-1:0]        gnt_idx,
  output logic                    gnt_valid,
  output logic                    hold_timeout
);

  localparam int N     = 1 << IDX_W;
  localparam int CNT_W = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   ptr, ptr_d;
  logic [IDX_W-1:0]   idx_d;
  logic               valid_d;
  logic               to_d;
  logic [CNT_W-1:0]   hold_cnt, cnt_d;

  logic [IDX_W-1:0]   arb_base;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic               timeout;
  logic               release_g;

  // On release the new pointer (holder+1) is used for arbitration in the same
  // cycle, so the search base is taken from gnt_idx rather than the stale ptr.
  assign arb_base  = (state == GRANT) ? gnt_idx + IDX_W'(1) : ptr;
  assign timeout   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign release_g = done | ~req[gnt_idx] | timeout;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = arb_base + IDX_W'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    idx_d   = gnt_idx;
    valid_d = gnt_valid;
    cnt_d   = hold_cnt;
    to_d    = 1'b0;
    case (state)
      IDLE: begin
        valid_d = 1'b0;
        if (|req) begin
          idx_d   = winner;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_g) begin
          ptr_d = gnt_idx + IDX_W'(1);
          // Pulse only when the limit alone forced the release.
          to_d  = timeout & ~done & req[gnt_idx];
          if (|req) begin
            idx_d   = winner;
            valid_d = 1'b1;
            cnt_d   = '0;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else if (hold_cnt != '1) begin
          cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      gnt_idx      <= '0;
      gnt_valid    <= 1'b0;
      hold_timeout <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      state        <= state_d;
      ptr          <= ptr_d;
      gnt_idx      <= idx_d;
      gnt_valid    <= valid_d;
      hold_timeout <= to_d;
      hold_cnt     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_grant_indexer.sv
module tb_rr_grant_indexer;

  localparam int MAXH = 16;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       hold_timeout;

  int checks = 0;
  int errors = 0;

  rr_grant_indexer #(.IDX_W(3), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .hold_timeout(hold_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: tenure counts cycles the holder has had gnt_valid high.
  int m_ptr = 0;
  int m_idx = 0;
  bit m_valid = 0;
  bit m_to = 0;
  int m_ten = 0;
  bit tmo, rel;

  function automatic int search(int p, logic [7:0] r);
    for (int i = 0; i < 8; i++)
      if (r[(p + i) % 8]) return (p + i) % 8;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ptr = 0; m_idx = 0; m_valid = 0; m_to = 0; m_ten = 0;
    end else begin
      m_to = 0;
      if (!m_valid) begin
        if (req != 8'h00) begin
          m_idx = search(m_ptr, req); m_valid = 1; m_ten = 1;
        end
      end else begin
        tmo = (MAXH != 0) && (m_ten == MAXH);
        rel = done || !req[m_idx] || tmo;
        if (rel) begin
          m_to  = tmo && !done && req[m_idx];
          m_ptr = (m_idx + 1) % 8;
          if (req != 8'h00) begin
            m_idx = search(m_ptr, req); m_ten = 1;
          end else begin
            m_valid = 0;
          end
        end else begin
          m_ten++;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_valid", int'(gnt_valid), int'(m_valid));
    chk("model_idx", int'(gnt_idx), m_idx);
    chk("model_timeout", int'(hold_timeout), int'(m_to));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] one = 8'd1;
  logic [7:0] dec;
  int n;

  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    cyc(2);
    chk("reset_valid", int'(gnt_valid), 0);
    chk("reset_idx", int'(gnt_idx), 0);
    chk("reset_timeout", int'(hold_timeout), 0);

    // 1: single requester 2
    rst = 1'b0; req = 8'b0000_0100;
    cyc(1);
    chk("t1_valid", int'(gnt_valid), 1);
    chk("t1_idx", int'(gnt_idx), 2);
    dec = one << gnt_idx;
    chk("t1_decoder", int'(dec), 4);
    req = 8'h00;
    cyc(1);
    chk("t1_idle_valid", int'(gnt_valid), 0);
    chk("t1_idle_idx_kept", int'(gnt_idx), 2);

    // 2: ptr=0, requesters 0 and 7 alternate on done
    rst = 1'b1; cyc(1); rst = 1'b0;
    req = 8'b1000_0001;
    cyc(1);
    chk("t2_first", int'(gnt_idx), 0);
    done = 1'b1;
    cyc(1);
    chk("t2_second", int'(gnt_idx), 7);
    chk("t2_no_bubble", int'(gnt_valid), 1);
    cyc(1);
    chk("t2_third", int'(gnt_idx), 0);
    done = 1'b0; req = 8'h00;
    cyc(1);

    // 3: holder 3 drops its request while 5 waits (ptr now 1)
    req = 8'b0000_1000;
    cyc(3);
    chk("t3_hold3", int'(gnt_idx), 3);
    req = 8'b0010_0000;
    cyc(1);
    chk("t3_idx5", int'(gnt_idx), 5);
    chk("t3_ptr4", int'(dut.ptr), 4);
    req = 8'h00;
    cyc(1);

    // 5: grant 6, then released with ptr=7 -> wraps to 0 (ptr now 6)
    req = 8'b0100_0000;
    cyc(1);
    chk("t5_idx6", int'(gnt_idx), 6);
    req = 8'b0100_0001;
    cyc(1);
    chk("t5_nonholder_ignored", int'(gnt_idx), 6);
    done = 1'b1;
    cyc(1);
    chk("t5_wrap", int'(gnt_idx), 0);
    done = 1'b0; req = 8'h00;
    cyc(1);

    // 4: sole requester 1 held to the limit (ptr now 1)
    req = 8'b0000_0010;
    cyc(1);
    n = 1;
    while (!hold_timeout && n < 40) begin
      cyc(1);
      n++;
    end
    chk("t4_tenure_cycles", n - 1, 16);
    chk("t4_pulse", int'(hold_timeout), 1);
    chk("t4_regrant_idx", int'(gnt_idx), 1);
    chk("t4_regrant_valid", int'(gnt_valid), 1);
    cyc(1);
    chk("t4_pulse_one_cycle", int'(hold_timeout), 0);
    // done coincides with the next timeout edge: no pulse
    cyc(14);
    done = 1'b1;
    cyc(1);
    chk("t4_done_and_timeout", int'(hold_timeout), 0);
    chk("t4_done_regrant", int'(gnt_idx), 1);
    done = 1'b0; req = 8'h00;
    cyc(1);

    // 6: reset mid-grant (ptr now 2)
    req = 8'hFF;
    cyc(2);
    chk("t6_pre_idx", int'(gnt_idx), 2);
    rst = 1'b1;
    cyc(1);
    chk("t6_rst_valid", int'(gnt_valid), 0);
    chk("t6_rst_idx", int'(gnt_idx), 0);
    rst = 1'b0;
    cyc(1);
    chk("t6_after_idx", int'(gnt_idx), 0);
    chk("t6_after_valid", int'(gnt_valid), 1);
    req = 8'h00;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
